morse_seq_ctrl: RTL

MORSE_SEQ_CTRL -- requirements
Module: morse_seq_ctrl

---
 rtl/morse_pkg.sv | 18 +
 rtl/morse_seq_ctrl_if.sv | 26 ++
 rtl/morse_seq_ctrl_edge_det.sv | 24 ++
 rtl/morse_seq_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared widths, default timings and the controller state type for the Morse key sequencer.
package morse_pkg;

    localparam int CNT_W  = 12;
    localparam int LEN_W  = 3;
    localparam int BITS_W = 4;

    localparam int DOT_MAX_T_DEF = 200;
    localparam int GAP_T_DEF     = 600;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/morse_seq_ctrl_if.sv
// Key/button inputs and letter/pulse outputs of the Morse sequencer, bundled for port passing.
interface morse_seq_ctrl_if;
    import morse_pkg::*;

    logic              en;
    logic              tick;
    logic              key_in;
    logic              bksp_btn;
    logic [BITS_W-1:0] sym_bits;
    logic [LEN_W-1:0]  sym_len;
    logic              commit;
    logic              bksp;
    logic              ovf;
    logic              busy;

    modport master (
        output en, tick, key_in, bksp_btn,
        input  sym_bits, sym_len, commit, bksp, ovf, busy
    );

    modport slave (
        input  en, tick, key_in, bksp_btn,
        output sym_bits, sym_len, commit, bksp, ovf, busy
    );

endinterface

// File: rtl/morse_seq_ctrl_edge_det.sv
// Level-to-edge detector: compares the live level against its registered copy.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;
    assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/morse_seq_ctrl.sv
// Turns timed key presses into a dot/dash letter buffer, committing it after a silent gap
// and offering backspace/overflow pulses to the display register.
module morse_seq_ctrl
    import morse_pkg::*;
#(
    parameter int DOT_MAX_T = DOT_MAX_T_DEF,
    parameter int GAP_T     = GAP_T_DEF
) (
    input logic             clk,
    input logic             rst,
    morse_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX_T);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_T - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BITS_W);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              bksp_q, bksp_d;
    logic              ovf_q, ovf_d;

    logic key_rise, key_fall;
    logic bksp_rise, bksp_fall_unused;

    // Edge registers run regardless of en, so re-enabling with the key held is not a press.
    edge_det u_key_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (bus.key_in),
        .rise_o  (key_rise),
        .fall_o  (key_fall)
    );

    edge_det u_bksp_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (bus.bksp_btn),
        .rise_o  (bksp_rise),
        .fall_o  (bksp_fall_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            bits_q  <= '0;
            bksp_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bits_q  <= bits_d;
            bksp_q  <= bksp_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        bits_d  = bits_q;
        bksp_d  = 1'b0;
        ovf_d   = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            len_d   = '0;
            bits_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_rise) begin
                        state_d = ST_PRESS;
                        cnt_d   = '0;
                    end
                    if (bksp_rise) begin
                        bksp_d = 1'b1;
                    end
                end

                ST_PRESS: begin
                    if (key_fall) begin
                        cnt_d = '0;
                        if (len_q < LEN_FULL) begin
                            bits_d[len_q[1:0]] = (cnt_q >= DOT_LIM);
                            len_d              = len_q + LEN_W'(1);
                            state_d            = ST_GAP;
                        end else begin
                            ovf_d   = 1'b1;
                            len_d   = '0;
                            bits_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end else if (bus.tick && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                // Backspace beats key rise, and both beat gap expiry in the same cycle.
                ST_GAP: begin
                    if (bksp_rise) begin
                        len_d   = '0;
                        bits_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (key_rise) begin
                        cnt_d   = '0;
                        state_d = ST_PRESS;
                    end else if (bus.tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == GAP_LAST) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end

                ST_COMMIT: begin
                    len_d   = '0;
                    bits_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sym_bits = bits_q;
    assign bus.sym_len  = len_q;
    assign bus.commit   = bus.en & (state_q == ST_COMMIT);
    assign bus.bksp     = bus.en & bksp_q;
    assign bus.ovf      = bus.en & ovf_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule
